mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl_pkg.sv | 66 ++++++
 rtl/mem_access_ctrl_load_align.sv | 35 +++
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared op encodings, bus size codes, FSM state type and op decode helpers
// for the MEM-stage access controller.
package mem_access_ctrl_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
            default:                         is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store_op = 1'b1;
            default:                         is_store_op = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_size = MEM_SIZE_B;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = MEM_SIZE_H;
            default:                          op_size = MEM_SIZE_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: is_misaligned = addr_lo[0];
            EXE_LW_OP, EXE_SW_OP:             is_misaligned = |addr_lo;
            default:                          is_misaligned = 1'b0;
        endcase
    endfunction

    // Replicate the store operand across every lane the bus might sample.
    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] wdata);
        case (op)
            EXE_SB_OP: store_data = {4{wdata[7:0]}};
            EXE_SH_OP: store_data = {2{wdata[15:0]}};
            default:   store_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load-data alignment: selects the addressed byte/half of a raw
// bus word and sign- or zero-extends it. Also used by the forwarding path.
module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = raw[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lanes[addr_lo];
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
        case (op)
            EXE_LB_OP:  data = {{24{byte_sel[7]}}, byte_sel};
            EXE_LBU_OP: data = {24'd0, byte_sel};
            EXE_LH_OP:  data = {{16{half_sel[15]}}, half_sel};
            EXE_LHU_OP: data = {16'd0, half_sel};
            default:    data = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: alignment exceptions, SRAM-like bus
// handshake (req / addr_ok / data_ok), load alignment and pipeline stall.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    input  logic        flush,
    input  logic        hold,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata_out,
    output logic        mem_stall,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr
);

    state_t      state_reg, state_next;
    logic [7:0]  op_reg;
    logic [1:0]  addr_lo_reg;
    logic        store_reg;
    logic [31:0] wdata_reg;
    logic        flush_seen_reg, flush_seen_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        latch_en;

    logic        mem_op, cur_store, misalign, issue;
    logic        req_c, wr_c, stall_c;
    logic [1:0]  size_c;
    logic [31:0] wdata_c, rdata_c, aligned;

    assign mem_op    = valid & is_mem_op(op);
    assign cur_store = is_store_op(op);
    assign misalign  = mem_op & is_misaligned(op, addr[1:0]);
    assign issue     = mem_op & ~misalign & ~flush;

    assign adel      = misalign & ~cur_store;
    assign ades      = misalign & cur_store;
    assign badvaddr  = misalign ? addr : 32'd0;

    mem_access_ctrl_load_align u_load_align (
        .op      (op_reg),
        .addr_lo (addr_lo_reg),
        .raw     (data_rdata),
        .data    (aligned)
    );

    always_comb begin
        state_next      = state_reg;
        flush_seen_next = flush_seen_reg;
        rdata_next      = rdata_reg;
        latch_en        = 1'b0;
        req_c           = 1'b0;
        wr_c            = 1'b0;
        stall_c         = 1'b0;
        size_c          = op_size(op);
        wdata_c         = store_data(op, wdata_in);
        rdata_c         = rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                flush_seen_next = 1'b0;
                if (issue) begin
                    req_c      = 1'b1;
                    wr_c       = cur_store;
                    stall_c    = 1'b1;
                    latch_en   = 1'b1;
                    state_next = data_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                // An issued request is never withdrawn; a flush only marks
                // the eventual response for discard.
                req_c   = 1'b1;
                wr_c    = store_reg;
                size_c  = op_size(op_reg);
                wdata_c = wdata_reg;
                stall_c = 1'b1;
                if (flush) begin
                    flush_seen_next = 1'b1;
                end
                if (data_addr_ok) begin
                    state_next = (flush_seen_reg | flush) ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_c = ~data_data_ok;
                if (data_data_ok) begin
                    if (flush) begin
                        state_next = ST_IDLE;
                    end else begin
                        if (!store_reg) begin
                            rdata_next = aligned;
                            rdata_c    = aligned;
                        end
                        state_next = hold ? ST_DONE : ST_IDLE;
                    end
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!hold) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                stall_c = 1'b1;
                if (data_data_ok) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are forced low for as long as reset is asserted.
    assign data_req   = req_c & rst;
    assign data_wr    = wr_c & rst;
    assign mem_stall  = stall_c & rst;
    assign data_size  = size_c;
    assign data_addr  = addr;
    assign data_wdata = wdata_c;
    assign rdata_out  = rdata_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            op_reg         <= 8'd0;
            addr_lo_reg    <= 2'd0;
            store_reg      <= 1'b0;
            wdata_reg      <= 32'd0;
            flush_seen_reg <= 1'b0;
            rdata_reg      <= 32'd0;
        end else begin
            state_reg      <= state_next;
            flush_seen_reg <= flush_seen_next;
            rdata_reg      <= rdata_next;
            if (latch_en) begin
                op_reg      <= op;
                addr_lo_reg <= addr[1:0];
                store_reg   <= cur_store;
                wdata_reg   <= wdata_c;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: single-transaction vector table plus
// hand-written multi-cycle sequences (stall, flush, hold, reset).
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic        flush;
    logic        hold;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] rdata_out;
    logic        mem_stall;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .op           (op),
        .addr         (addr),
        .wdata_in     (wdata_in),
        .flush        (flush),
        .hold         (hold),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .rdata_out    (rdata_out),
        .mem_stall    (mem_stall),
        .adel         (adel),
        .ades         (ades),
        .badvaddr     (badvaddr)
    );

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        logic        exp_adel;
        logic        exp_ades;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string nm, input logic [7:0] o, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input logic rq,
                           input logic wr, input logic [1:0] sz, input logic [31:0] ewd,
                           input logic el, input logic es, input logic [31:0] erd);
        vec_t v;
        v.name = nm; v.op = o; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.exp_req = rq; v.exp_wr = wr; v.exp_size = sz; v.exp_wdata = ewd;
        v.exp_adel = el; v.exp_ades = es; v.exp_rdata = erd;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; op = 8'd0; addr = 32'd0; wdata_in = 32'd0;
        flush = 1'b0; hold = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = 32'd0;
    endtask

    task automatic start_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] wd,
                            input logic aok);
        valid = 1'b1; op = o; addr = a; wdata_in = wd; data_addr_ok = aok; data_data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //       name      op          addr          wdata         rdata         rq wr size ewdata        el es erdata
        add_vec("lw",     EXE_LW_OP,  32'h80001000, 32'h0,        32'h12345678, 1, 0, 2, 32'h0,        0, 0, 32'h12345678);
        add_vec("lb3",    EXE_LB_OP,  32'h80001003, 32'h0,        32'h80AABBCC, 1, 0, 0, 32'h0,        0, 0, 32'hFFFFFF80);
        add_vec("lbu3",   EXE_LBU_OP, 32'h80001003, 32'h0,        32'h80AABBCC, 1, 0, 0, 32'h0,        0, 0, 32'h00000080);
        add_vec("lhu2",   EXE_LHU_OP, 32'h80001002, 32'h0,        32'h80AABBCC, 1, 0, 1, 32'h0,        0, 0, 32'h000080AA);
        add_vec("lh0",    EXE_LH_OP,  32'h80001000, 32'h0,        32'h1234F00D, 1, 0, 1, 32'h0,        0, 0, 32'hFFFFF00D);
        add_vec("lb1",    EXE_LB_OP,  32'h80001001, 32'h0,        32'h80AABBCC, 1, 0, 0, 32'h0,        0, 0, 32'hFFFFFFBB);
        add_vec("lbu0",   EXE_LBU_OP, 32'h80001000, 32'h0,        32'h80AABBCC, 1, 0, 0, 32'h0,        0, 0, 32'h000000CC);
        add_vec("sb2",    EXE_SB_OP,  32'h80001002, 32'h000000AB, 32'h99999999, 1, 1, 0, 32'hABABABAB, 0, 0, 32'h0);
        add_vec("sh4",    EXE_SH_OP,  32'h80001004, 32'h1234CDEF, 32'h99999999, 1, 1, 1, 32'hCDEFCDEF, 0, 0, 32'h0);
        add_vec("sw8",    EXE_SW_OP,  32'h80001008, 32'hDEADBEEF, 32'h99999999, 1, 1, 2, 32'hDEADBEEF, 0, 0, 32'h0);
        add_vec("sh1err", EXE_SH_OP,  32'h80001001, 32'h00001111, 32'h0,        0, 0, 0, 32'h0,        0, 1, 32'h0);
        add_vec("sw1err", EXE_SW_OP,  32'h80001001, 32'h00001111, 32'h0,        0, 0, 0, 32'h0,        0, 1, 32'h0);
        add_vec("lw2err", EXE_LW_OP,  32'h80001002, 32'h0,        32'h0,        0, 0, 0, 32'h0,        1, 0, 32'h0);
        add_vec("lh3err", EXE_LH_OP,  32'h80001003, 32'h0,        32'h0,        0, 0, 0, 32'h0,        1, 0, 32'h0);
        add_vec("lhu1err",EXE_LHU_OP, 32'h80001001, 32'h0,        32'h0,        0, 0, 0, 32'h0,        1, 0, 32'h0);
        add_vec("nonmem", 8'h21,      32'h80001001, 32'h0,        32'h0,        0, 0, 0, 32'h0,        0, 0, 32'h0);

        idle_inputs();
        rst = 1'b0;
        #12;
        chk("reset.req",   32'(data_req),  32'd0);
        chk("reset.wr",    32'(data_wr),   32'd0);
        chk("reset.stall", 32'(mem_stall), 32'd0);
        chk("reset.rdata", rdata_out,      32'd0);
        $display("txn reset checked");
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            logic [31:0] exp_bad;
            v = vq[i];
            next_cycle();
            start_op(v.op, v.addr, v.wdata, 1'b1);
            @(negedge clk);
            exp_bad = (v.exp_adel | v.exp_ades) ? v.addr : 32'd0;
            chk({v.name, ".req"},   32'(data_req),  32'(v.exp_req));
            chk({v.name, ".wr"},    32'(data_wr),   32'(v.exp_wr));
            chk({v.name, ".adel"},  32'(adel),      32'(v.exp_adel));
            chk({v.name, ".ades"},  32'(ades),      32'(v.exp_ades));
            chk({v.name, ".bad"},   badvaddr,       exp_bad);
            chk({v.name, ".stall"}, 32'(mem_stall), 32'(v.exp_req));
            if (v.exp_req) begin
                chk({v.name, ".addr"}, data_addr, v.addr);
                chk({v.name, ".size"}, 32'(data_size), 32'(v.exp_size));
                if (v.exp_wr) chk({v.name, ".wdata"}, data_wdata, v.exp_wdata);
                next_cycle();
                data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = v.rdata;
                if (!v.exp_wr) model_rdata = v.exp_rdata;
                @(negedge clk);
                chk({v.name, ".dstall"}, 32'(mem_stall), 32'd0);
                chk({v.name, ".rdata"},  rdata_out,      model_rdata);
                next_cycle();
                valid = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h5A5A5A5A;
                @(negedge clk);
                chk({v.name, ".rdata_reg"}, rdata_out,      model_rdata);
                chk({v.name, ".idle_req"},  32'(data_req),  32'd0);
            end else begin
                next_cycle();
                idle_inputs();
            end
            $display("txn %0s op=%h addr=%h rdata_out=%h", v.name, v.op, v.addr, rdata_out);
        end

        // Address phase stretched: addr_ok low for three cycles.
        next_cycle();
        start_op(EXE_SW_OP, 32'h80002000, 32'h11223344, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stretch.req%0d", k),   32'(data_req),  32'd1);
            chk($sformatf("stretch.addr%0d", k),  data_addr,      32'h80002000);
            chk($sformatf("stretch.wdata%0d", k), data_wdata,     32'h11223344);
            chk($sformatf("stretch.stall%0d", k), 32'(mem_stall), 32'd1);
            next_cycle();
        end
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("stretch.req_acc",   32'(data_req),  32'd1);
        chk("stretch.stall_acc", 32'(mem_stall), 32'd1);
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        @(negedge clk);
        chk("stretch.done_stall", 32'(mem_stall), 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("stretch.idle_req", 32'(data_req), 32'd0);
        $display("txn stretch sw complete");

        // Flush while waiting for data; data_ok two cycles later is drained.
        next_cycle();
        start_op(EXE_LW_OP, 32'h80003000, 32'h0, 1'b1);
        next_cycle();
        data_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flushwait.stall0", 32'(mem_stall), 32'd1);
        next_cycle();
        flush = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("flushwait.stall1", 32'(mem_stall), 32'd1);
        next_cycle();
        data_data_ok = 1'b1; data_rdata = 32'hCAFEBABE;
        @(negedge clk);
        chk("flushwait.stall2", 32'(mem_stall), 32'd1);
        chk("flushwait.rdata2", rdata_out,      model_rdata);
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("flushwait.stall3", 32'(mem_stall), 32'd0);
        chk("flushwait.rdata3", rdata_out,      model_rdata);
        $display("txn flush-in-wait complete");

        // Flush while the request is still pending: request held until accepted.
        next_cycle();
        start_op(EXE_LW_OP, 32'h80003004, 32'h0, 1'b0);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("flushreq.req0", 32'(data_req), 32'd1);
        next_cycle();
        flush = 1'b0; valid = 1'b0; data_addr_ok = 1'b1;
        @(negedge clk);
        chk("flushreq.req1", 32'(data_req), 32'd1);
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADDEAD;
        @(negedge clk);
        chk("flushreq.stall_drain", 32'(mem_stall), 32'd1);
        chk("flushreq.rdata_drain", rdata_out,      model_rdata);
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("flushreq.stall_idle", 32'(mem_stall), 32'd0);
        chk("flushreq.rdata_idle", rdata_out,      model_rdata);
        $display("txn flush-in-req complete");

        // data_ok and flush in the same WAIT cycle.
        next_cycle();
        start_op(EXE_LBU_OP, 32'h80003001, 32'h0, 1'b1);
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; flush = 1'b1; data_rdata = 32'h0000FF00;
        @(negedge clk);
        chk("okflush.stall", 32'(mem_stall), 32'd0);
        chk("okflush.rdata", rdata_out,      model_rdata);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("okflush.idle_stall", 32'(mem_stall), 32'd0);
        chk("okflush.idle_rdata", rdata_out,      model_rdata);
        $display("txn data_ok+flush complete");

        // Later-stage hold when data arrives: result held in DONE.
        next_cycle();
        start_op(EXE_LH_OP, 32'h80004002, 32'h0, 1'b1);
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; hold = 1'b1; data_rdata = 32'h80011234;
        model_rdata = 32'hFFFF8001;
        @(negedge clk);
        chk("hold.stall_ok", 32'(mem_stall), 32'd0);
        chk("hold.rdata_ok", rdata_out,      model_rdata);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            data_data_ok = 1'b0; data_rdata = 32'h77777777;
            if (k == 2) hold = 1'b0;
            @(negedge clk);
            chk($sformatf("hold.stall%0d", k), 32'(mem_stall), 32'd0);
            chk($sformatf("hold.req%0d", k),   32'(data_req),  32'd0);
            chk($sformatf("hold.rdata%0d", k), rdata_out,      model_rdata);
        end
        next_cycle();
        valid = 1'b0;
        @(negedge clk);
        chk("hold.rdata_idle", rdata_out, model_rdata);
        $display("txn hold complete rdata_out=%h", rdata_out);

        // Reset asserted in WAIT; a late data_ok must be ignored.
        next_cycle();
        start_op(EXE_LW_OP, 32'h80005000, 32'h0, 1'b1);
        next_cycle();
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("rstwait.stall_pre", 32'(mem_stall), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        model_rdata = 32'd0;
        chk("rstwait.req",   32'(data_req),  32'd0);
        chk("rstwait.wr",    32'(data_wr),   32'd0);
        chk("rstwait.stall", 32'(mem_stall), 32'd0);
        chk("rstwait.rdata", rdata_out,      model_rdata);
        next_cycle();
        rst = 1'b1; valid = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h12121212;
        @(negedge clk);
        chk("rstwait.late_stall", 32'(mem_stall), 32'd0);
        chk("rstwait.late_rdata", rdata_out,      model_rdata);
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("rstwait.after_rdata", rdata_out, model_rdata);
        $display("txn reset-in-wait complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
